audio_echo_fx: RTL and testbench
================================

Name: audio_echo_fx

Overview:
- Feedback-comb echo/reverb stage, one per stereo stream.
- Sits between the I2S capture logic (parallel left/right samples plus LRCK-edge strobes) and the SRAM record / DAC output path.
- Each strobe pulls the delayed sample for that channel from an on-chip circular buffer, computes y = x + g·y[n−D] with saturation, writes y back, and presents y downstream.
- Runs on the 50 MHz system clock. Sample rate is thousands of cycles per frame, so one single-port RAM time-shares both channels.

Parameters:
- DEPTH, 4096, maximum delay in frames per channel; RAM holds 2*DEPTH words of 16 bits.
- AW, 12, frame-pointer width; must equal clog2(DEPTH).
- GSH, 4, gain fraction bits; gain is fb_gain/2^GSH.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- RST  in  1  asynchronous active-low reset.
- strb_l  in  1  one-cycle strobe, left sample valid (LRCK rising edge).
- strb_r  in  1  one-cycle strobe, right sample valid (LRCK falling edge).
- in_l  in  16  signed left input sample.
- in_r  in  16  signed right input sample.
- delay_len  in  AW  delay D in frames; 0 is treated as 1.
- fb_gain  in  GSH  unsigned feedback gain, 0..15/16.
- bypass  in  1  1 = out equals input; the buffer is still written with the input.
- out_l  out  16  signed left result.
- out_r  out  16  signed right result.
- vld_l  out  1  one-cycle pulse when out_l updates.
- vld_r  out  1  one-cycle pulse when out_r updates.
- busy  out  1  high during CLEAR or while a sample is in flight.

Behaviour:
- Reset (async, RST=0): out_l=out_r=0, vld_l=vld_r=0, busy=1, ptr=0, pending flags=0, FSM enters CLEAR.
- CLEAR:
  - Writes 0 to RAM addresses 0..2*DEPTH−1, one per cycle, then goes to IDLE; busy then drops.
  - Strobes arriving during CLEAR are passed dry: out=in, vld pulses 1 cycle later, nothing is written.
- Reset asserted mid-operation aborts any in-flight sample. No vld is generated for it, and CLEAR restarts from address 0.
- Strobe capture:
  - Each strobe latches its sample into hold_l or hold_r and sets pend_l or pend_r.
  - A strobe arriving while busy is held, never dropped.
  - If both channels are pending, left is served first.
  - A second strobe on the same channel before service overwrites hold and keeps a single pend.
- FSM, with RAM address {ptr, ch}:
  - IDLE: if pend, select ch and clear its pend → RD.
  - RD: issue RAM read → MUL (RAM has 1-cycle read latency).
  - MUL: p = d * {0,fb_gain}, 21-bit signed; w = p >>> GSH → SUM.
  - SUM: s = x + w in 18 bits; saturate to [−32768, 32767]; if bypass, y = x → WR.
  - WR: write y to {ptr, ch}; drive out_ch = y and pulse vld_ch. If ch=R, advance ptr. → IDLE.
- Latency: strobe in IDLE → vld pulse in exactly 5 cycles (capture, RD, MUL, SUM, WR).
- Pointer:
  - Advances once per frame, after the right channel.
  - ptr_next = (ptr+1 ≥ Deff) ? 0 : ptr+1, where Deff = max(delay_len, 1).
  - If delay_len shrinks below ptr, the next advance wraps ptr to 0.
  - Changing delay_len never causes a RAM access outside 0..2*DEPTH−1.
- fb_gain=0: y=x exactly. Gain and bypass are sampled in SUM, so changes apply from the next sample.
- Saturation is symmetric and clamps. No wrap-around is permitted.

Optional Feature:
- Macro: AUDIO_ECHO_CLIP_FLAG_EN.
- Defined: adds input clip_clr (1 bit) and output clip_led (1 bit).
  - clip_led is set sticky in any SUM cycle where saturation changes the value.
  - Cleared by clip_clr=1 (clip_clr has priority over a simultaneous set) or by reset.
- Undefined: neither port exists; saturation behaviour is unchanged.

Test Plan:
- Reset then idle → busy high for 8192 cycles (DEPTH=4096), then low; out_l=out_r=0. A strobe_l with in_l=1234 during CLEAR gives out_l=1234 with vld_l one cycle later.
- Impulse, after CLEAR: delay_len=4, fb_gain=8, in_l=16384 in frame 0 then zeros → out_l = 16384, 8192, 4096, 2048 in frames 0, 4, 8, 12; 0 in all other frames; out_r=0 throughout.
- Saturation: delay_len=1, fb_gain=15, in_l=30000 every frame → out_l=30000, then 32767 from frame 1 onward, never negative. With the macro defined, clip_led=1 until clip_clr is asserted.
- Simultaneous strb_l and strb_r in the same cycle (in_l=100, in_r=−200, gain 0) → vld_l at +5 cycles with out_l=100, vld_r at +9 cycles with out_r=−200.
- Wrap/length change: run 10 frames at delay_len=8, switch to delay_len=3 while ptr=6 → ptr returns to 0 at the next frame end, then cycles 0,1,2. No RAM address ≥ 2*DEPTH is seen.
- Reset pulse while the FSM is in MUL → no vld pulse, outputs 0, CLEAR restarts. Bypass=1 with gain 15 → out equals in exactly.

Source files
------------

// File: rtl/audio_echo_fx.sv
// audio_echo_fx: stereo feedback-comb echo, y = x + g*y[n-D] with saturation.
// One single-port RAM holds both channels' delay lines, interleaved as {ptr, ch}.
// Optional build macro AUDIO_ECHO_CLIP_FLAG_EN adds a sticky clip indicator
// (clip_led) with a clear input (clip_clr).
module audio_echo_fx #(
   parameter int DEPTH = 4096,  // maximum delay in frames per channel
   parameter int AW    = 12,    // frame-pointer width, clog2(DEPTH)
   parameter int GSH   = 4      // gain fraction bits
) (
   input  logic                 CLOCK_50,
   input  logic                 RST,
   input  logic                 strb_l,
   input  logic                 strb_r,
   input  logic signed [15:0]   in_l,
   input  logic signed [15:0]   in_r,
   input  logic [AW-1:0]        delay_len,
   input  logic [GSH-1:0]       fb_gain,
   input  logic                 bypass,
   output logic signed [15:0]   out_l,
   output logic signed [15:0]   out_r,
   output logic                 vld_l,
   output logic                 vld_r,
   output logic                 busy
`ifdef AUDIO_ECHO_CLIP_FLAG_EN
   ,
   input  logic                 clip_clr,
   output logic                 clip_led
`endif
);

   localparam int DATA_W = 16;
   localparam int RAW    = AW + 1;               // RAM address: {ptr, ch}
   localparam int PW     = DATA_W + GSH + 1;     // product / sum width
   localparam logic [RAW-1:0] CLR_LAST = RAW'(2 * DEPTH - 1);
   localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [PW-1:0] SAT_MIN = PW'(-(2 ** (DATA_W - 1)));

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_RD,
      S_MUL,
      S_SUM,
      S_WR
   } state_t;

   state_t                    state, state_nx;
   logic                      pend_l, pend_r;
   logic                      ch;
   logic [AW-1:0]             ptr, ptr_nx;
   logic [RAW-1:0]            clr_addr;
   logic                      req_l, req_r;
   logic                      disp, disp_ch;
   logic                      ram_we;
   logic [RAW-1:0]            ram_addr;
   logic signed [DATA_W-1:0]  ram_wdata;
   logic [AW:0]               ptr_inc, d_eff;

   logic signed [DATA_W-1:0]  mem [0:2*DEPTH-1];
   logic signed [DATA_W-1:0]  hold_l, hold_r;
   logic signed [DATA_W-1:0]  x_p0;
   logic signed [DATA_W-1:0]  rd_p1;
   logic signed [PW-1:0]      w_p2;
   logic signed [DATA_W-1:0]  y_p3;
   logic signed [PW-1:0]      d_ext, g_ext, p_full, p_sh, s_full;

   // Clamp a wide sum into the signed sample range; never wraps.
   function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [PW-1:0] v);
      if (v > SAT_MAX)
         return {1'b0, {(DATA_W-1){1'b1}}};
      else if (v < SAT_MIN)
         return {1'b1, {(DATA_W-1){1'b0}}};
      else
         return v[DATA_W-1:0];
   endfunction

   // A request is either an already-pending sample or one strobing in right now,
   // so an idle engine starts RD on the cycle after the strobe.
   assign req_l = pend_l | strb_l;
   assign req_r = pend_r | strb_r;
   assign busy  = (state != S_IDLE) | pend_l | pend_r;

   // Frame pointer wraps against the effective delay; a shrinking delay wraps at once.
   assign ptr_inc = {1'b0, ptr} + RAW'(1);
   assign d_eff   = (delay_len == '0) ? RAW'(1) : {1'b0, delay_len};
   assign ptr_nx  = (ptr_inc >= d_eff) ? '0 : ptr_inc[AW-1:0];

   // Feedback arithmetic: gain is unsigned, so it enters the product with a zero sign bit.
   assign d_ext  = {{(PW-DATA_W){rd_p1[DATA_W-1]}}, rd_p1};
   assign g_ext  = {{(PW-GSH){1'b0}}, fb_gain};
   assign p_full = d_ext * g_ext;
   assign p_sh   = p_full >>> GSH;
   assign s_full = {{(PW-DATA_W){x_p0[DATA_W-1]}}, x_p0} + w_p2;

   // State register; reset aborts any in-flight sample and restarts CLEAR.
   always_ff @(posedge CLOCK_50 or negedge RST) begin
      if (!RST)
         state <= S_CLEAR;
      else
         state <= state_nx;
   end

   // Next-state, dispatch and RAM port control; WR hands straight over to the next request.
   always_comb begin
      state_nx  = state;
      disp      = 1'b0;
      disp_ch   = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = {ptr, ch};
      ram_wdata = y_p3;
      case (state)
         S_CLEAR: begin
            ram_we    = 1'b1;
            ram_addr  = clr_addr;
            ram_wdata = '0;
            if (clr_addr == CLR_LAST)
               state_nx = S_IDLE;
         end
         S_IDLE: begin
            if (req_l | req_r) begin
               disp     = 1'b1;
               disp_ch  = ~req_l;
               state_nx = S_RD;
            end
         end
         S_RD:  state_nx = S_MUL;
         S_MUL: state_nx = S_SUM;
         S_SUM: state_nx = S_WR;
         S_WR: begin
            ram_we   = 1'b1;
            state_nx = S_IDLE;
            if (req_l | req_r) begin
               disp     = 1'b1;
               disp_ch  = ~req_l;
               state_nx = S_RD;
            end
         end
         default: state_nx = S_CLEAR;
      endcase
   end

   // Pending flags, channel select, frame pointer and clear address.
   always_ff @(posedge CLOCK_50 or negedge RST) begin
      if (!RST) begin
         pend_l   <= 1'b0;
         pend_r   <= 1'b0;
         ch       <= 1'b0;
         ptr      <= '0;
         clr_addr <= '0;
      end else begin
         pend_l <= (disp && !disp_ch) ? 1'b0 : (pend_l | (strb_l && state != S_CLEAR));
         pend_r <= (disp &&  disp_ch) ? 1'b0 : (pend_r | (strb_r && state != S_CLEAR));
         if (disp)
            ch <= disp_ch;
         if (state == S_WR && ch)
            ptr <= ptr_nx;
         if (state == S_CLEAR)
            clr_addr <= (clr_addr == CLR_LAST) ? '0 : clr_addr + RAW'(1);
      end
   end

   // Single-port delay RAM with one-cycle registered read.
   always_ff @(posedge CLOCK_50) begin
      if (ram_we)
         mem[ram_addr] <= ram_wdata;
      else
         rd_p1 <= mem[ram_addr];
   end

   // Sample datapath: capture, MUL and SUM registers.
   always_ff @(posedge CLOCK_50) begin
      if (strb_l)
         hold_l <= in_l;
      if (strb_r)
         hold_r <= in_r;
      // p0: sample selected at dispatch; a same-cycle strobe is the newest value
      if (disp)
         x_p0 <= disp_ch ? (strb_r ? in_r : hold_r) : (strb_l ? in_l : hold_l);
      // p2: scaled feedback term
      if (state == S_MUL)
         w_p2 <= p_sh;
      // p3: saturated result, or the dry input in bypass
      if (state == S_SUM)
         y_p3 <= bypass ? x_p0 : sat_data(s_full);
   end

   // Output registers: dry pass-through during CLEAR, processed result from WR.
   always_ff @(posedge CLOCK_50 or negedge RST) begin
      if (!RST) begin
         out_l <= '0;
         out_r <= '0;
         vld_l <= 1'b0;
         vld_r <= 1'b0;
      end else begin
         vld_l <= 1'b0;
         vld_r <= 1'b0;
         if (state == S_CLEAR) begin
            if (strb_l) begin
               out_l <= in_l;
               vld_l <= 1'b1;
            end
            if (strb_r) begin
               out_r <= in_r;
               vld_r <= 1'b1;
            end
         end else if (state == S_WR) begin
            if (ch) begin
               out_r <= y_p3;
               vld_r <= 1'b1;
            end else begin
               out_l <= y_p3;
               vld_l <= 1'b1;
            end
         end
      end
   end

`ifdef AUDIO_ECHO_CLIP_FLAG_EN
   logic clipped;
   assign clipped = !bypass && ((s_full > SAT_MAX) || (s_full < SAT_MIN));

   // Sticky clip indicator; clear wins over a simultaneous clip.
   always_ff @(posedge CLOCK_50 or negedge RST) begin
      if (!RST)
         clip_led <= 1'b0;
      else if (clip_clr)
         clip_led <= 1'b0;
      else if (state == S_SUM && clipped)
         clip_led <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_audio_echo_fx.sv
// tb_audio_echo_fx: scoreboard bench for audio_echo_fx with a frame-level echo model.
module tb_audio_echo_fx;
   localparam int DEPTH = 4096;
   localparam int AW    = 12;
   localparam int GSH   = 4;

   logic                CLOCK_50 = 1'b0;
   logic                RST;
   logic                strb_l, strb_r;
   logic signed [15:0]  in_l, in_r;
   logic [AW-1:0]       delay_len;
   logic [GSH-1:0]      fb_gain;
   logic                bypass;
   logic signed [15:0]  out_l, out_r;
   logic                vld_l, vld_r, busy;
`ifdef AUDIO_ECHO_CLIP_FLAG_EN
   logic                clip_clr, clip_led;
`endif

   audio_echo_fx #(.DEPTH(DEPTH), .AW(AW), .GSH(GSH)) dut (
      .CLOCK_50 (CLOCK_50),
      .RST      (RST),
      .strb_l   (strb_l),
      .strb_r   (strb_r),
      .in_l     (in_l),
      .in_r     (in_r),
      .delay_len(delay_len),
      .fb_gain  (fb_gain),
      .bypass   (bypass),
      .out_l    (out_l),
      .out_r    (out_r),
      .vld_l    (vld_l),
      .vld_r    (vld_r),
      .busy     (busy)
`ifdef AUDIO_ECHO_CLIP_FLAG_EN
      ,
      .clip_clr (clip_clr),
      .clip_led (clip_led)
`endif
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int cyc = 0;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;
   int exp_l[$];
   int exp_r[$];
   int last_l_cyc = -1;
   int last_r_cyc = -1;
   int last_strb_cyc = 0;
   bit in_clear = 1'b1;

   // Reference model: one delay line per channel, indexed by the frame pointer.
   int ml[DEPTH];
   int mr[DEPTH];
   int mptr = 0;

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         ml[i] = 0;
         mr[i] = 0;
      end
      mptr = 0;
   endfunction

   function automatic int model_step(input bit ch, input int x);
      int d, w, s, y, nxt, deff;
      d = ch ? mr[mptr] : ml[mptr];
      w = (d * int'(fb_gain)) >>> GSH;
      s = x + w;
      if (bypass)         y = x;
      else if (s > 32767) y = 32767;
      else if (s < -32768) y = -32768;
      else                y = s;
      if (ch) mr[mptr] = y;
      else    ml[mptr] = y;
      if (ch) begin
         deff = (delay_len == 0) ? 1 : int'(delay_len);
         nxt  = mptr + 1;
         mptr = (nxt >= deff) ? 0 : nxt;
      end
      return y;
   endfunction

   function automatic int rnd16();
      logic signed [15:0] t;
      t = 16'($urandom);
      return int'(t);
   endfunction

   // Monitor: every output pulse pops the expected value for its channel.
   initial begin
      forever begin
         @(posedge CLOCK_50);
         #1;
         if (vld_l) begin
            last_l_cyc = cyc;
            if (exp_l.size() == 0) check("unexpected_vld_l", int'(vld_l), 0);
            else check("out_l", int'(out_l), exp_l.pop_front());
         end
         if (vld_r) begin
            last_r_cyc = cyc;
            if (exp_r.size() == 0) check("unexpected_vld_r", int'(vld_r), 0);
            else check("out_r", int'(out_r), exp_r.pop_front());
         end
      end
   end

   task automatic send(input bit ch, input int x, input bit use_exp, input int req);
      int y;
      @(negedge CLOCK_50);
      y = in_clear ? x : model_step(ch, x);
      if (use_exp) y = req;
      if (ch) begin
         exp_r.push_back(y);
         in_r   = 16'(x);
         strb_r = 1'b1;
      end else begin
         exp_l.push_back(y);
         in_l   = 16'(x);
         strb_l = 1'b1;
      end
      last_strb_cyc = cyc;
      @(negedge CLOCK_50);
      strb_l = 1'b0;
      strb_r = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge CLOCK_50);
         #1;
         if (!busy) return;
      end
      check("idle_timeout", int'(busy), 0);
   endtask

   task automatic frame(input int l, input int r, input bit use_exp, input int el, input int er);
      send(1'b0, l, use_exp, el);
      wait_idle(40);
      send(1'b1, r, use_exp, er);
      wait_idle(40);
   endtask

   task automatic assert_reset();
      @(negedge CLOCK_50);
      RST = 1'b0;
      exp_l.delete();
      exp_r.delete();
      model_reset();
      in_clear = 1'b1;
      #1;
      check("rst_out_l", int'(out_l), 0);
      check("rst_out_r", int'(out_r), 0);
      check("rst_vld", int'({vld_l, vld_r}), 0);
      check("rst_busy", int'(busy), 1);
      repeat (3) @(posedge CLOCK_50);
   endtask

   task automatic release_and_clear(input bit dry);
      int c_r;
      @(negedge CLOCK_50);
      RST = 1'b1;
      c_r = cyc;
      if (dry) begin
         repeat (5) @(posedge CLOCK_50);
         send(1'b0, 1234, 1'b1, 1234);
         repeat (3) @(posedge CLOCK_50);
         #2;
         check("dry_latency", last_l_cyc - last_strb_cyc, 1);
      end
      for (int i = 0; i < 9000; i++) begin
         @(posedge CLOCK_50);
         #1;
         if (!busy) break;
      end
      check("clear_cycles", cyc - c_r, 2 * DEPTH);
      check("post_clear_out_r", int'(out_r), 0);
      in_clear = 1'b0;
   endtask

   initial begin
      RST = 1'b0; strb_l = 1'b0; strb_r = 1'b0; in_l = '0; in_r = '0;
      delay_len = 12'd4; fb_gain = 4'd0; bypass = 1'b0;
`ifdef AUDIO_ECHO_CLIP_FLAG_EN
      clip_clr = 1'b0;
`endif
      model_reset();

      // Power-up reset, clear with a dry sample in flight.
      assert_reset();
      release_and_clear(1'b1);

      // Impulse response: 16384 halves every 4 frames, right stays silent.
      delay_len = 12'd4; fb_gain = 4'd8; bypass = 1'b0;
      for (int n = 0; n < 16; n++) begin
         int el;
         el = (n == 0) ? 16384 : (n == 4) ? 8192 : (n == 8) ? 4096 : (n == 12) ? 2048 : 0;
         frame((n == 0) ? 16384 : 0, 0, 1'b1, el, 0);
      end

      // Simultaneous strobes: left served first.
      fb_gain = 4'd0;
      @(negedge CLOCK_50);
      begin
         int yl, yr;
         yl = model_step(1'b0, 100);
         yr = model_step(1'b1, -200);
         exp_l.push_back(100);
         exp_r.push_back(-200);
         check("model_simul", yl + yr, -100);
      end
      in_l = 16'sd100; in_r = -16'sd200; strb_l = 1'b1; strb_r = 1'b1;
      last_strb_cyc = cyc;
      @(negedge CLOCK_50);
      strb_l = 1'b0; strb_r = 1'b0;
      wait_idle(40);
      @(posedge CLOCK_50);
      #2;
      check("lat_l", last_l_cyc - last_strb_cyc, 5);
      check("lat_r", last_r_cyc - last_strb_cyc, 9);

      // Saturation: flush slot 0 at gain 0, then a hot input every frame.
      delay_len = 12'd1;
      frame(0, 0, 1'b0, 0, 0);
      frame(0, 0, 1'b0, 0, 0);
      fb_gain = 4'd15;
      for (int n = 0; n < 6; n++)
         frame(30000, 0, 1'b1, (n == 0) ? 30000 : 32767, 0);
`ifdef AUDIO_ECHO_CLIP_FLAG_EN
      check("clip_set", int'(clip_led), 1);
      @(negedge CLOCK_50); clip_clr = 1'b1;
      @(negedge CLOCK_50); clip_clr = 1'b0;
      #1;
      check("clip_clr", int'(clip_led), 0);
`endif

      // Wrap: long delay, bring pointer to 6, then shrink the delay.
      delay_len = 12'd8; fb_gain = 4'd8;
      for (int n = 0; n < 10; n++) frame(rnd16(), rnd16(), 1'b0, 0, 0);
      for (int i = 0; i < 8 && mptr != 6; i++) frame(rnd16(), rnd16(), 1'b0, 0, 0);
      delay_len = 12'd3;
      for (int n = 0; n < 10; n++) frame(rnd16(), rnd16(), 1'b0, 0, 0);

      // Randomized gain, delay and bypass.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            delay_len = 12'($urandom_range(0, 20));
            fb_gain   = 4'($urandom);
            bypass    = ($urandom_range(0, 5) == 0);
         end
         frame(rnd16(), rnd16(), 1'b0, 0, 0);
      end

      // Bypass with maximum gain: output is the input exactly.
      bypass = 1'b1; fb_gain = 4'd15;
      for (int n = 0; n < 4; n++) begin
         int a, b;
         a = rnd16();
         b = rnd16();
         frame(a, b, 1'b1, a, b);
      end
      bypass = 1'b0;

      // Reset while a sample sits in MUL: no pulse, outputs cleared, CLEAR restarts.
      fb_gain = 4'd8;
      @(negedge CLOCK_50);
      in_l = 16'sd5000; strb_l = 1'b1;
      @(negedge CLOCK_50);
      strb_l = 1'b0;
      assert_reset();
      release_and_clear(1'b0);
      delay_len = 12'd2;
      for (int n = 0; n < 6; n++) frame(rnd16(), rnd16(), 1'b0, 0, 0);

      repeat (4) @(posedge CLOCK_50);
      #2;
      check("left_queue_drained", exp_l.size(), 0);
      check("right_queue_drained", exp_r.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
